// File: rtl/gfx_serial_rx.sv
// gfx_serial_rx: UART receiver that hunts for SYNC_BYTE and writes big-endian 16-bit words 0..WORDS-1.
// Optional macro GFX_SERIAL_PARITY_EN switches the line format from 8N1 to 8E1.
module gfx_serial_rx #(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         WORDS        = 1024,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_SERIAL_RX,
   output logic        RX_WR_EN,
   output logic [9:0]  RX_WR_ADDR,
   output logic [15:0] RX_WR_DATA,
   output logic        RX_FRAME_DONE,
   output logic        RX_ERROR,
   output logic        RX_BUSY
);

   localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [9:0]       LAST_ADDR = 10'(WORDS - 1);

   typedef enum logic [2:0] {
      B_IDLE,
      B_START,
      B_DATA,
`ifdef GFX_SERIAL_PARITY_EN
      B_PARITY,
`endif
      B_STOP
   } bit_state_t;

   typedef enum logic [1:0] {
      F_HUNT,
      F_HI,
      F_LO
   } frame_state_t;

`ifdef GFX_SERIAL_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      even_parity = ^d;
   endfunction
`endif

   logic             sync1_r, sync2_r, prev_r;
   bit_state_t       bit_state_r, bit_state_s;
   logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
   logic [2:0]       bit_idx_r, bit_idx_s;
   logic [7:0]       shift_r, shift_s;
   logic             byte_ok_s, byte_err_s;

   frame_state_t     frame_state_r, frame_state_s;
   logic [7:0]       hi_r, hi_s;
   logic [9:0]       addr_r, addr_s;
   logic [9:0]       wr_addr_r, wr_addr_s;
   logic [15:0]      wr_data_r, wr_data_s;
   logic             wr_en_r, wr_en_s;
   logic             done_r, done_s;
   logic             err_r, err_s;
   logic             busy_r, busy_s;

   // Line synchronizer plus a delayed copy used for falling-edge detection.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= IN_SERIAL_RX;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Bit engine state registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bit_state_r <= B_IDLE;
         bit_cnt_r   <= '0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'd0;
      end else begin
         bit_state_r <= bit_state_s;
         bit_cnt_r   <= bit_cnt_s;
         bit_idx_r   <= bit_idx_s;
         shift_r     <= shift_s;
      end
   end

   // Bit engine next state; byte_ok_s/byte_err_s fire in the cycle of the final sample.
   always_comb begin
      bit_state_s = bit_state_r;
      bit_cnt_s   = bit_cnt_r;
      bit_idx_s   = bit_idx_r;
      shift_s     = shift_r;
      byte_ok_s   = 1'b0;
      byte_err_s  = 1'b0;
      case (bit_state_r)
         B_IDLE: begin
            if (prev_r && !sync2_r) begin
               bit_state_s = B_START;
               bit_cnt_s   = '0;
            end else begin
               bit_state_s = B_IDLE;
            end
         end
         B_START: begin
            if (bit_cnt_r == HALF_M1) begin
               bit_cnt_s = '0;
               bit_idx_s = 3'd0;
               if (!sync2_r) begin
                  bit_state_s = B_DATA;
               end else begin
                  bit_state_s = B_IDLE;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 1'b1;
            end
         end
         B_DATA: begin
            if (bit_cnt_r == FULL_M1) begin
               bit_cnt_s = '0;
               shift_s   = {sync2_r, shift_r[7:1]};
               if (bit_idx_r == 3'd7) begin
`ifdef GFX_SERIAL_PARITY_EN
                  bit_state_s = B_PARITY;
`else
                  bit_state_s = B_STOP;
`endif
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 1'b1;
            end
         end
`ifdef GFX_SERIAL_PARITY_EN
         B_PARITY: begin
            if (bit_cnt_r == FULL_M1) begin
               bit_cnt_s = '0;
               if (sync2_r != even_parity(shift_r)) begin
                  byte_err_s  = 1'b1;
                  bit_state_s = B_IDLE;
               end else begin
                  bit_state_s = B_STOP;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 1'b1;
            end
         end
`endif
         B_STOP: begin
            if (bit_cnt_r == FULL_M1) begin
               bit_cnt_s   = '0;
               bit_state_s = B_IDLE;
               if (sync2_r) begin
                  byte_ok_s = 1'b1;
               end else begin
                  byte_err_s = 1'b1;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 1'b1;
            end
         end
         default: begin
            bit_state_s = B_IDLE;
            bit_cnt_s   = '0;
         end
      endcase
   end

   // Frame engine state and registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         frame_state_r <= F_HUNT;
         hi_r          <= 8'd0;
         addr_r        <= 10'd0;
         wr_addr_r     <= 10'd0;
         wr_data_r     <= 16'd0;
         wr_en_r       <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         frame_state_r <= frame_state_s;
         hi_r          <= hi_s;
         addr_r        <= addr_s;
         wr_addr_r     <= wr_addr_s;
         wr_data_r     <= wr_data_s;
         wr_en_r       <= wr_en_s;
         done_r        <= done_s;
         err_r         <= err_s;
         busy_r        <= busy_s;
      end
   end

   // Frame engine next state; an error anywhere abandons the frame without writing.
   always_comb begin
      frame_state_s = frame_state_r;
      hi_s          = hi_r;
      addr_s        = addr_r;
      wr_addr_s     = wr_addr_r;
      wr_data_s     = wr_data_r;
      wr_en_s       = 1'b0;
      done_s        = 1'b0;
      err_s         = 1'b0;
      busy_s        = busy_r;
      if (byte_err_s) begin
         err_s         = 1'b1;
         addr_s        = 10'd0;
         busy_s        = 1'b0;
         frame_state_s = F_HUNT;
      end else if (byte_ok_s) begin
         case (frame_state_r)
            F_HUNT: begin
               if (shift_r == SYNC_BYTE) begin
                  frame_state_s = F_HI;
                  busy_s        = 1'b1;
                  addr_s        = 10'd0;
               end else begin
                  frame_state_s = F_HUNT;
               end
            end
            F_HI: begin
               hi_s          = shift_r;
               frame_state_s = F_LO;
            end
            F_LO: begin
               wr_en_s   = 1'b1;
               wr_addr_s = addr_r;
               wr_data_s = {hi_r, shift_r};
               if (addr_r == LAST_ADDR) begin
                  done_s        = 1'b1;
                  addr_s        = 10'd0;
                  busy_s        = 1'b0;
                  frame_state_s = F_HUNT;
               end else begin
                  addr_s        = addr_r + 10'd1;
                  frame_state_s = F_HI;
               end
            end
            default: begin
               frame_state_s = F_HUNT;
               busy_s        = 1'b0;
               addr_s        = 10'd0;
            end
         endcase
      end else begin
         frame_state_s = frame_state_r;
      end
   end

   assign RX_WR_EN      = wr_en_r;
   assign RX_WR_ADDR    = wr_addr_r;
   assign RX_WR_DATA    = wr_data_r;
   assign RX_FRAME_DONE = done_r;
   assign RX_ERROR      = err_r;
   assign RX_BUSY       = busy_r;

endmodule

// File: tb/tb_gfx_serial_rx.sv
// tb_gfx_serial_rx: byte-level reference model of the frame receiver, driven with randomized UART traffic.
// Honours GFX_SERIAL_PARITY_EN in the same way as the design.
module tb_gfx_serial_rx;

   localparam int CPB   = 16;
   localparam int WORDS = 4;
`ifdef GFX_SERIAL_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   localparam logic [7:0]  FRAME1   [9] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
   localparam logic [15:0] F1_WORDS [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};

   logic        CLK = 1'b0;
   logic        RESET;
   logic        line;
   logic        RX_WR_EN;
   logic [9:0]  RX_WR_ADDR;
   logic [15:0] RX_WR_DATA;
   logic        RX_FRAME_DONE;
   logic        RX_ERROR;
   logic        RX_BUSY;

   gfx_serial_rx #(
      .CLKS_PER_BIT(CPB),
      .WORDS       (WORDS),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .IN_SERIAL_RX (line),
      .RX_WR_EN     (RX_WR_EN),
      .RX_WR_ADDR   (RX_WR_ADDR),
      .RX_WR_DATA   (RX_WR_DATA),
      .RX_FRAME_DONE(RX_FRAME_DONE),
      .RX_ERROR     (RX_ERROR),
      .RX_BUSY      (RX_BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int addr;
      int data;
      int done;
      int t0;
   } wr_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   wr_t  exp_q[$];
   int   log_addr[$];
   int   log_data[$];
   int   log_done[$];
   int   err_exp = 0;
   int   err_seen = 0;
   int   m_busy = 0;
   int   m_n = 0;
   logic [7:0] m_hi = 8'd0;
   int   hold_addr = 0;
   int   hold_data = 0;
   logic prev_wr = 1'b0;
   logic prev_err = 1'b0;
   wr_t  ce;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Byte-level model: count data bytes after a sync byte; every odd one completes a word.
   task automatic model_byte(input logic [7:0] b, input bit bad, input int t0);
      wr_t e;
      if (bad) begin
         err_exp++;
         m_busy = 0;
         m_n    = 0;
      end else if (m_busy == 0) begin
         if (b == 8'hA5) begin
            m_busy = 1;
            m_n    = 0;
         end
      end else begin
         if (m_n % 2 == 0) begin
            m_hi = b;
         end else begin
            e.addr = m_n / 2;
            e.data = int'({m_hi, b});
            e.done = (m_n / 2 == WORDS - 1) ? 1 : 0;
            e.t0   = t0;
            exp_q.push_back(e);
            if (e.done == 1) m_busy = 0;
         end
         m_n++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
      int t0;
      int gap;
      check("busy_before_byte", int'(RX_BUSY), m_busy);
      gap = $urandom_range(0, 24);
      @(negedge CLK);
      line = 1'b0;
      t0 = cyc;
      model_byte(b, bad_stop || bad_par, t0);
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         repeat (CPB) @(negedge CLK);
      end
`ifdef GFX_SERIAL_PARITY_EN
      line = (^b) ^ bad_par;
      repeat (CPB) @(negedge CLK);
`endif
      line = ~bad_stop;
      repeat (CPB) @(negedge CLK);
      line = 1'b1;
      repeat (gap + 8) @(negedge CLK);
      check("error_count", err_seen, err_exp);
      check("write_queue_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      m_busy = 0;
      m_n = 0;
      hold_addr = 0;
      hold_data = 0;
      repeat (3) @(negedge CLK);
      check("reset_wr_en", int'(RX_WR_EN), 0);
      check("reset_addr", int'(RX_WR_ADDR), 0);
      check("reset_data", int'(RX_WR_DATA), 0);
      check("reset_done", int'(RX_FRAME_DONE), 0);
      check("reset_error", int'(RX_ERROR), 0);
      check("reset_busy", int'(RX_BUSY), 0);
      check("reset_queue_empty", exp_q.size(), 0);
      RESET = 1'b0;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_done.delete();
   endtask

   // Per-cycle compare of the write port against the model's expected writes.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      #1;
      if (RESET) begin
         prev_wr  = 1'b0;
         prev_err = 1'b0;
      end else begin
         check("wr_pulse_width", int'(RX_WR_EN & prev_wr), 0);
         check("err_pulse_width", int'(RX_ERROR & prev_err), 0);
         if (RX_WR_EN) begin
            check("unexpected_write", (exp_q.size() == 0) ? 1 : 0, 0);
            if (exp_q.size() != 0) begin
               ce = exp_q.pop_front();
               check("wr_addr", int'(RX_WR_ADDR), ce.addr);
               check("wr_data", int'(RX_WR_DATA), ce.data);
               check("frame_done", int'(RX_FRAME_DONE), ce.done);
               check("wr_timing",
                     ((cyc >= ce.t0 + (9 + PAR_BITS) * CPB + CPB / 2 - 2) &&
                      (cyc <= ce.t0 + (10 + PAR_BITS) * CPB)) ? 1 : 0, 1);
               hold_addr = ce.addr;
               hold_data = ce.data;
            end
            log_addr.push_back(int'(RX_WR_ADDR));
            log_data.push_back(int'(RX_WR_DATA));
            log_done.push_back(int'(RX_FRAME_DONE));
         end else begin
            check("done_without_write", int'(RX_FRAME_DONE), 0);
            check("addr_hold", int'(RX_WR_ADDR), hold_addr);
            check("data_hold", int'(RX_WR_DATA), hold_data);
         end
         if (RX_ERROR) err_seen++;
         prev_wr  = RX_WR_EN;
         prev_err = RX_ERROR;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rb;
      bit         bs;
      bit         bp;
      int         nnoise;
      RESET = 1'b1;
      line  = 1'b1;
      do_reset();
      repeat (4) @(negedge CLK);

      // Short low pulse on the line must be rejected as a glitch.
      @(negedge CLK);
      line = 1'b0;
      repeat (4) @(negedge CLK);
      line = 1'b1;
      repeat (3 * CPB) @(negedge CLK);
      check("glitch_no_error", err_seen, 0);
      check("glitch_no_write", log_addr.size(), 0);
      check("glitch_not_busy", int'(RX_BUSY), 0);

      // Reference frame with hand-computed results.
      clear_log();
      for (int i = 0; i < 9; i++) send_byte(FRAME1[i], 1'b0, 1'b0);
      check("f1_write_count", log_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("f1_addr", log_addr[i], i);
         check("f1_data", log_data[i], int'(F1_WORDS[i]));
         check("f1_done", log_done[i], (i == 3) ? 1 : 0);
      end
      check("f1_busy_after", int'(RX_BUSY), 0);

      // Noise before sync, then repeated sync values taken as data.
      clear_log();
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h7E, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 1'b0);
      check("resync_first_addr", log_addr[0], 0);
      check("resync_first_data", log_data[0], 16'hA5A5);
      check("resync_write_count", log_addr.size(), 4);

      // Framing error on the second data byte, then a clean frame.
      clear_log();
      send_byte(8'hA5, 1'b0, 1'b0);
      send_byte(8'h5A, 1'b0, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b0);
      check("ferr_no_write", log_addr.size(), 0);
      check("ferr_error_seen", err_seen, 1);
      check("ferr_busy_drop", int'(RX_BUSY), 0);
      for (int i = 0; i < 9; i++) send_byte(FRAME1[i], 1'b0, 1'b0);
      check("ferr_next_addr0", log_addr[0], 0);
      check("ferr_next_data0", log_data[0], 16'h1234);

      // Reset in the middle of word 2, then a full frame.
      clear_log();
      send_byte(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
      @(negedge CLK);
      line = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         line = i[0];
         repeat (CPB) @(negedge CLK);
      end
      line = 1'b1;
      do_reset();
      repeat (2 * CPB) @(negedge CLK);
      clear_log();
      for (int i = 0; i < 9; i++) send_byte(FRAME1[i], 1'b0, 1'b0);
      check("rst_next_addr0", log_addr[0], 0);
      check("rst_next_data0", log_data[0], 16'h1234);

`ifdef GFX_SERIAL_PARITY_EN
      // Wrong even-parity bit on 0x12 is an error; correct parity is accepted.
      clear_log();
      send_byte(8'hA5, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b1);
      check("par_bad_no_write", log_addr.size(), 0);
      check("par_bad_busy_drop", int'(RX_BUSY), 0);
      for (int i = 0; i < 9; i++) send_byte(FRAME1[i], 1'b0, 1'b0);
      check("par_good_data0", log_data[0], 16'h1234);
`endif

      // Randomized frames with noise, embedded sync values and occasional line errors.
      for (int f = 0; f < 6; f++) begin
         nnoise = $urandom_range(0, 2);
         for (int k = 0; k < nnoise; k++) send_byte(8'($urandom), 1'b0, 1'b0);
         send_byte(8'hA5, 1'b0, 1'b0);
         for (int k = 0; k < 2 * WORDS; k++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            bs = ($urandom_range(0, 24) == 0);
`ifdef GFX_SERIAL_PARITY_EN
            bp = ($urandom_range(0, 24) == 0);
`else
            bp = 1'b0;
`endif
            send_byte(rb, bs, bp);
         end
      end

      repeat (4 * CPB) @(negedge CLK);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_error_count", err_seen, err_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
